mem_port_arbiter: RTL

Multi-cycle scheduler for the single-ported instruction/data block RAM behind the ControlUnit.
It shares the one RAM port between three requesters:
- the IF stage (instruction fetch),
- the MEM stage (load/store),
- the infer debug readout (infer/infer_addr path used to inspect memory after a run).
It serialises accesses, sequences the RAM's fixed read latency, and returns data with a one-cycle ack pulse.

---
 rtl/mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Serialises IF, MEM and debug-readout accesses onto one RAM port.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int DBG_MAX_WAIT = 4
) (
    input  logic              fast_clk,
    input  logic              rst,
    input  logic              top_en,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic [1:0]        grant_id
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_IF   = 2'd1;
    localparam logic [1:0] G_MEM  = 2'd2;
    localparam logic [1:0] G_DBG  = 2'd3;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY);
    localparam logic [3:0] WAIT_MAX = 4'(DBG_MAX_WAIT);

    logic [1:0]        state_q, state_d;
    logic [2:0]        lat_q, lat_d;
    logic [3:0]        wait_q, wait_d;
    logic              store_q, store_d;
    logic [1:0]        grant_id_q, grant_id_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              mem_ack_q, mem_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              busy_q, busy_d;

    logic [1:0]        w_winner;
    logic              w_grant;
    logic              w_expire;

    // State and registered-output storage
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            wait_q      <= '0;
            store_q     <= 1'b0;
            grant_id_q  <= G_NONE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            dbg_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            wait_q      <= wait_d;
            store_q     <= store_d;
            grant_id_q  <= grant_id_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Arbitration and next-state; a starved debug request overrides priority
    always_comb begin
        w_winner = G_NONE;
        if (dbg_req && (wait_q == WAIT_MAX)) begin
            w_winner = G_DBG;
        end else if (mem_req && top_en) begin
            w_winner = G_MEM;
        end else if (if_req && top_en) begin
            w_winner = G_IF;
        end else if (dbg_req) begin
            w_winner = G_DBG;
        end

        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (w_winner != G_NONE) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                lat_d   = LAT_INIT;
            end
            S_WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_grant  = (state_q == S_IDLE) && (w_winner != G_NONE);
    assign w_expire = (state_q == S_WAIT) && (lat_q == 3'd1);

    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        store_d     = store_q;
        grant_id_d  = grant_id_q;
        wait_d      = wait_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        busy_d      = (state_d != S_IDLE);

        if (w_grant) begin
            ram_en_d   = 1'b1;
            grant_id_d = w_winner;
            case (w_winner)
                G_MEM: begin
                    ram_addr_d = mem_addr;
                    store_d    = mem_we;
                    ram_we_d   = mem_we;
                    if (mem_we) begin
                        ram_wdata_d = mem_wdata;
                    end
                end
                G_IF: begin
                    ram_addr_d = if_addr;
                    store_d    = 1'b0;
                end
                default: begin
                    ram_addr_d = dbg_addr;
                    store_d    = 1'b0;
                end
            endcase
        end

        if (!dbg_req) begin
            wait_d = '0;
        end else if (w_grant) begin
            if (w_winner == G_DBG) begin
                wait_d = '0;
            end else if (wait_q != WAIT_MAX) begin
                wait_d = wait_q + 4'd1;
            end
        end

        // Stores acknowledge without touching the load-data register
        if (w_expire) begin
            case (grant_id_q)
                G_IF: begin
                    if_ack_d   = 1'b1;
                    if_rdata_d = ram_rdata;
                end
                G_MEM: begin
                    mem_ack_d = 1'b1;
                    if (!store_q) begin
                        mem_rdata_d = ram_rdata;
                    end
                end
                G_DBG: begin
                    dbg_ack_d   = 1'b1;
                    dbg_rdata_d = ram_rdata;
                end
                default: ;
            endcase
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule
`default_nettype wire
